// File: rtl/rx_d2c_pt_requester.sv
// Requester side of the RX data-to-clock point test: walks the partner through
// START / LFSR_CLR / pattern / COUNT_DONE / END over the sideband, drives the
// mainband pattern generator, and reports completion or response timeout.
//
// Sideband request handshake: o_encoded_SB_msg_tx is loaded on the edge that
// enters a SEND state and a pending flag is set; o_valid_tx rises on the first
// edge where the pending flag is set and neither i_SB_Busy nor i_rx_valid is
// high, clearing the flag. o_valid_tx stays high until i_falling_edge_busy
// pulses (the clear wins over any set), and that pulse moves SEND to WAIT.
module rx_d2c_pt_requester #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_pt_en,
  input  logic                    i_datavref_or_valvref,
  input  logic [CNT_WIDTH-1:0]    i_pattern_count,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_SB_Busy,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
  output logic                    o_valid_tx,
  output logic [1:0]              o_mainband_pattern_generator_cw,
  output logic                    o_valid_pattern_en,
  output logic                    o_pt_done,
  output logic                    o_pt_timeout,
  output logic [3:0]              o_fsm_state
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [SB_MSG_WIDTH-1:0] START_REQ       = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] START_RESP      = SB_MSG_WIDTH'(2);
  localparam logic [SB_MSG_WIDTH-1:0] LFSR_CLR_REQ    = SB_MSG_WIDTH'(3);
  localparam logic [SB_MSG_WIDTH-1:0] LFSR_CLR_RESP   = SB_MSG_WIDTH'(4);
  localparam logic [SB_MSG_WIDTH-1:0] COUNT_DONE_REQ  = SB_MSG_WIDTH'(5);
  localparam logic [SB_MSG_WIDTH-1:0] COUNT_DONE_RESP = SB_MSG_WIDTH'(6);
  localparam logic [SB_MSG_WIDTH-1:0] END_REQ         = SB_MSG_WIDTH'(7);
  localparam logic [SB_MSG_WIDTH-1:0] END_RESP        = SB_MSG_WIDTH'(8);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SEND_START = 4'd1,
    S_WAIT_START = 4'd2,
    S_SEND_CLR   = 4'd3,
    S_WAIT_CLR   = 4'd4,
    S_PATTERN    = 4'd5,
    S_SEND_CNT   = 4'd6,
    S_WAIT_CNT   = 4'd7,
    S_SEND_END   = 4'd8,
    S_WAIT_END   = 4'd9,
    S_FINISHED   = 4'd10
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [CNT_WIDTH-1:0]      latched_count;
  logic [CNT_WIDTH-1:0]      pattern_cnt;
  logic [TW-1:0]             timeout_cnt;
  logic                      pending;

  logic                      is_send;
  logic                      is_wait;
  logic                      next_is_send;
  logic                      next_is_wait;
  logic [SB_MSG_WIDTH-1:0]   resp_code;
  logic [SB_MSG_WIDTH-1:0]   next_req_code;
  logic                      resp_match;
  logic                      pattern_last;
  logic                      timeout_hit;
  logic                      entering;
  logic                      clear_all;

  assign o_fsm_state  = state;
  assign resp_match   = is_wait && i_rx_msg_valid && (i_decoded_SB_msg == resp_code);
  assign pattern_last = (latched_count == '0) ||
                        (pattern_cnt == latched_count - CNT_WIDTH'(1));
  assign timeout_hit  = (timeout_cnt == T_LAST);
  assign entering     = (next_state != state);
  assign clear_all    = i_rst || (next_state == S_IDLE);

  // Classify current and next state; pick the expected response and next request code.
  always_comb begin
    is_send       = 1'b0;
    is_wait       = 1'b0;
    resp_code     = '0;
    next_is_send  = 1'b0;
    next_is_wait  = 1'b0;
    next_req_code = '0;
    case (state)
      S_SEND_START, S_SEND_CLR, S_SEND_CNT, S_SEND_END: is_send = 1'b1;
      S_WAIT_START: begin is_wait = 1'b1; resp_code = START_RESP;      end
      S_WAIT_CLR:   begin is_wait = 1'b1; resp_code = LFSR_CLR_RESP;   end
      S_WAIT_CNT:   begin is_wait = 1'b1; resp_code = COUNT_DONE_RESP; end
      S_WAIT_END:   begin is_wait = 1'b1; resp_code = END_RESP;        end
      default: ;
    endcase
    case (next_state)
      S_SEND_START: begin next_is_send = 1'b1; next_req_code = START_REQ;      end
      S_SEND_CLR:   begin next_is_send = 1'b1; next_req_code = LFSR_CLR_REQ;   end
      S_SEND_CNT:   begin next_is_send = 1'b1; next_req_code = COUNT_DONE_REQ; end
      S_SEND_END:   begin next_is_send = 1'b1; next_req_code = END_REQ;        end
      S_WAIT_START, S_WAIT_CLR, S_WAIT_CNT, S_WAIT_END: next_is_wait = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; dropping i_pt_en aborts from anywhere.
  always_comb begin
    next_state = state;
    if (!i_pt_en) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:       next_state = S_SEND_START;
        S_SEND_START: if (i_falling_edge_busy && o_valid_tx) next_state = S_WAIT_START;
        S_SEND_CLR:   if (i_falling_edge_busy && o_valid_tx) next_state = S_WAIT_CLR;
        S_SEND_CNT:   if (i_falling_edge_busy && o_valid_tx) next_state = S_WAIT_CNT;
        S_SEND_END:   if (i_falling_edge_busy && o_valid_tx) next_state = S_WAIT_END;
        S_WAIT_START: if (resp_match) next_state = S_SEND_CLR;
                      else if (timeout_hit) next_state = S_FINISHED;
        S_WAIT_CLR:   if (resp_match) next_state = S_PATTERN;
                      else if (timeout_hit) next_state = S_FINISHED;
        S_WAIT_CNT:   if (resp_match) next_state = S_SEND_END;
                      else if (timeout_hit) next_state = S_FINISHED;
        S_WAIT_END:   if (resp_match || timeout_hit) next_state = S_FINISHED;
        S_PATTERN:    if (pattern_last) next_state = S_SEND_CNT;
        S_FINISHED:   next_state = S_FINISHED;
        default:      next_state = S_IDLE;
      endcase
    end
  end

  // Mainband pattern generator controls decoded from the current state.
  always_comb begin
    o_mainband_pattern_generator_cw = 2'b00;
    o_valid_pattern_en              = 1'b0;
    case (state)
      S_SEND_CLR, S_WAIT_CLR: begin
        if (!i_datavref_or_valvref) o_mainband_pattern_generator_cw = 2'b01;
      end
      S_PATTERN: begin
        if (!i_datavref_or_valvref) o_mainband_pattern_generator_cw = 2'b10;
        else                        o_valid_pattern_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Sideband request code, valid and pending flag.
  always_ff @(posedge i_clk) begin
    if (clear_all) begin
      o_encoded_SB_msg_tx <= '0;
      o_valid_tx          <= 1'b0;
      pending             <= 1'b0;
    end else if (entering && next_is_send) begin
      o_encoded_SB_msg_tx <= next_req_code;
      o_valid_tx          <= 1'b0;
      pending             <= 1'b1;
    end else if (is_send) begin
      if (i_falling_edge_busy) begin
        o_valid_tx <= 1'b0;
      end else if (pending && !i_SB_Busy && !i_rx_valid) begin
        o_valid_tx <= 1'b1;
        pending    <= 1'b0;
      end
    end
  end

  // Pattern length latch and pattern cycle counter.
  always_ff @(posedge i_clk) begin
    if (clear_all) begin
      latched_count <= '0;
      pattern_cnt   <= '0;
    end else begin
      if (state == S_IDLE) latched_count <= i_pattern_count;
      if (entering && next_state == S_PATTERN) pattern_cnt <= '0;
      else if (state == S_PATTERN && !pattern_last) pattern_cnt <= pattern_cnt + CNT_WIDTH'(1);
    end
  end

  // Response timeout counter, restarted on entry to every WAIT state.
  always_ff @(posedge i_clk) begin
    if (clear_all) begin
      timeout_cnt <= '0;
    end else if (entering && next_is_wait) begin
      timeout_cnt <= '0;
    end else if (is_wait && !timeout_hit) begin
      timeout_cnt <= timeout_cnt + TW'(1);
    end
  end

  // Sticky completion and timeout flags, held until the test is disabled.
  always_ff @(posedge i_clk) begin
    if (clear_all) begin
      o_pt_done    <= 1'b0;
      o_pt_timeout <= 1'b0;
    end else begin
      if (entering && next_state == S_FINISHED) o_pt_done <= 1'b1;
      if (is_wait && !resp_match && timeout_hit) o_pt_timeout <= 1'b1;
    end
  end

endmodule

// File: doc/rx_d2c_pt_requester.md
RX_D2C_PT_REQUESTER -- requirements
Module: rx_d2c_pt_requester

Interface
REQ-001 SHALL have parameter SB_MSG_WIDTH, default 4, the sideband message code width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the pattern-length counter width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum wait for any response.
REQ-004 SHALL use one clock and a synchronous active-high reset: i_clk in 1, rising-edge clock; i_rst in 1, synchronous active-high reset.
REQ-005 i_pt_en  in  1  LTSM enable; deassertion aborts the test.
REQ-006 i_datavref_or_valvref  in  1  0 = data lanes, 1 = valid lane.
REQ-007 i_pattern_count  in  CNT_WIDTH  pattern cycles to transmit, sampled on leaving IDLE.
REQ-008 i_rx_msg_valid  in  1  qualifies i_decoded_SB_msg.
REQ-009 i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message.
REQ-010 i_SB_Busy  in  1  sideband transmitter busy.
REQ-011 i_falling_edge_busy  in  1  one-cycle pulse: sideband consumed the current message.
REQ-012 i_rx_valid  in  1  co-located responder currently owns the sideband request bus.
REQ-013 o_encoded_SB_msg_tx  out  SB_MSG_WIDTH  message code to encode.
REQ-014 o_valid_tx  out  1  message request to wrapper.
REQ-015 o_mainband_pattern_generator_cw  out  2  00 IDLE, 01 CLEAR_LFSR, 10 LFSR, 11 unused.
REQ-016 o_valid_pattern_en  out  1  valid-lane pattern generator enable.
REQ-017 o_pt_done  out  1  test complete, held until i_pt_en falls.
REQ-018 o_pt_timeout  out  1  response timeout, held until i_pt_en falls.

Function
REQ-019 Message codes SHALL be: START_REQ 1, START_RESP 2, LFSR_CLR_REQ 3, LFSR_CLR_RESP 4, COUNT_DONE_REQ 5, COUNT_DONE_RESP 6, END_REQ 7, END_RESP 8.
REQ-020 States SHALL be: IDLE, SEND_START, WAIT_START, SEND_CLR, WAIT_CLR, PATTERN, SEND_CNT, WAIT_CNT, SEND_END, WAIT_END, FINISHED.
REQ-021 IDLE→SEND_START when i_pt_en=1, latching i_pattern_count.
REQ-022 On entry to each SEND_x state, o_encoded_SB_msg_tx SHALL load that state's REQ code on the same edge.
REQ-023 o_valid_tx SHALL set one cycle after entering SEND_x when i_SB_Busy=0 and i_rx_valid=0; otherwise set a pending flag and raise o_valid_tx on the first cycle both are 0.
REQ-024 The pending flag SHALL clear when o_valid_tx rises.
REQ-025 o_valid_tx SHALL clear on i_falling_edge_busy; this has priority over the set condition.
REQ-026 SEND_x→WAIT_x on the cycle i_falling_edge_busy=1 while o_valid_tx=1.
REQ-027 WAIT_x→next state when i_rx_msg_valid=1 and the code equals the matching RESP; other codes are ignored.
REQ-028 Transitions: WAIT_START→SEND_CLR, WAIT_CLR→PATTERN, WAIT_CNT→SEND_END, WAIT_END→FINISHED.
REQ-029 In SEND_CLR and WAIT_CLR with data mode, cw SHALL be 01.
REQ-030 In PATTERN: data mode → cw=10; valid mode → o_valid_pattern_en=1.
REQ-031 The PATTERN counter SHALL count from 0; at count = latched value − 1, transition to SEND_CNT.
REQ-032 A latched value of 0 SHALL make PATTERN last exactly 1 cycle.
REQ-033 On leaving PATTERN, cw SHALL be 00 and o_valid_pattern_en SHALL be 0.
REQ-034 The timeout counter SHALL clear on entry to every WAIT_x.
REQ-035 At TIMEOUT_CYCLES−1 without a match, o_pt_timeout SHALL be 1 and the FSM SHALL move to FINISHED.
REQ-036 Entering FINISHED SHALL set o_pt_done=1.
REQ-037 i_pt_en=0 in any state SHALL force IDLE next cycle.
REQ-038 In IDLE all outputs, counters and the pending flag SHALL be 0.
REQ-039 A matching response arriving in a SEND_x state SHALL be ignored.

Reset
REQ-040 i_rst=1 at a clock edge SHALL force IDLE, clear both counters and the pending flag, and drive every output to 0, mid-operation included.

Verification
REQ-041 Nominal data test, count=4, immediate responses → messages 1,3,5,7 issued in order; cw sequence 01, then 10 for exactly 4 cycles, then 00; o_pt_done=1.
REQ-042 Valid mode, count=0 → o_valid_pattern_en high for exactly 1 cycle; cw stays 00 throughout.
REQ-043 i_rx_valid=1 for 5 cycles when entering SEND_START → o_valid_tx rises the first cycle after i_rx_valid falls; msg=1.
REQ-044 No END_RESP received → o_pt_timeout=1 exactly TIMEOUT_CYCLES cycles after entering WAIT_END; o_pt_done=1.
REQ-045 Wrong code 6 while in WAIT_START → FSM stays in WAIT_START; a later code 2 → advances.
REQ-046 i_pt_en dropped during PATTERN, or i_rst pulsed → IDLE next cycle; all outputs 0.
